// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue unit: owns the PC and issues one instruction or bubble per cycle, with hardware RAW and branch-shadow bubbles.
// Issue outputs are registered one cycle after the fetch address. There is no back-pressure; the only stalls are hazard and branch bubbles.
module fetch_issue_ctrl #(
    parameter int HAZ_DEPTH = 3,
    parameter int BR_SHADOW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_addr,
    output logic [15:0] issue_inst,
    output logic        issue_valid,
    output logic        issue_bubble,
    output logic [7:0]  pc,
    output logic [15:0] bubble_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_BRANCH = 2'd2;

    localparam int SW = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

    logic [1:0]                 state_q, state_d;
    logic [7:0]                 pc_q, pc_d;
    logic [SW-1:0]              shadow_q, shadow_d;
    logic [15:0]                inst_q, inst_d;
    logic                       valid_q, valid_d;
    logic                       bubble_q, bubble_d;
    logic [15:0]                bcnt_q, bcnt_d;
    logic [HAZ_DEPTH-1:0]       hist_vld_q, hist_vld_d;
    logic [HAZ_DEPTH-1:0][2:0]  hist_dst_q, hist_dst_d;

    logic [2:0] opcode;
    logic       rd_a_vld, rd_b_vld, wr_vld;
    logic [2:0] rd_a, rd_b, wr_dst;
    logic       hazard;
    logic       push_vld;

    assign opcode = imem_data[15:13];

    // Source/destination extraction; the all-zero word is a NOP despite opcode 000.
    always_comb begin
        rd_a_vld = 1'b0;
        rd_b_vld = 1'b0;
        wr_vld   = 1'b0;
        rd_a     = 3'd0;
        rd_b     = 3'd0;
        wr_dst   = 3'd0;
        case (opcode)
            3'b000: begin
                if (imem_data != 16'h0000) begin
                    rd_a_vld = 1'b1;
                    rd_b_vld = 1'b1;
                    wr_vld   = 1'b1;
                    rd_a     = imem_data[2:0];
                    rd_b     = imem_data[5:3];
                    wr_dst   = imem_data[8:6];
                end
            end
            3'b001, 3'b010: begin
                rd_a_vld = 1'b1;
                wr_vld   = 1'b1;
                rd_a     = imem_data[5:3];
                wr_dst   = imem_data[2:0];
            end
            default: begin
                rd_a_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_vld_q[i] &&
                ((rd_a_vld && (hist_dst_q[i] == rd_a)) ||
                 (rd_b_vld && (hist_dst_q[i] == rd_b)))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        shadow_d = shadow_q;
        inst_d   = 16'h0000;
        valid_d  = 1'b0;
        bubble_d = 1'b0;
        push_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (hazard) begin
                    valid_d  = 1'b1;
                    bubble_d = 1'b1;
                end else begin
                    valid_d  = 1'b1;
                    inst_d   = imem_data;
                    pc_d     = pc_q + 8'd1;
                    push_vld = wr_vld;
                    if ((opcode == 3'b100) && (BR_SHADOW > 0)) begin
                        state_d  = ST_BRANCH;
                        shadow_d = SW'(BR_SHADOW);
                    end
                end
            end
            ST_BRANCH: begin
                valid_d  = 1'b1;
                bubble_d = 1'b1;
                shadow_d = shadow_q - SW'(1);
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                end
                if (shadow_q == SW'(1)) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Newest issue enters slot 0; bubbles, non-writers and paused cycles shift in invalid.
    always_comb begin
        hist_vld_d    = '0;
        hist_dst_d    = '0;
        hist_vld_d[0] = push_vld;
        hist_dst_d[0] = wr_dst;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            hist_vld_d[i] = hist_vld_q[i-1];
            hist_dst_d[i] = hist_dst_q[i-1];
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble_d && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= 8'd0;
            shadow_q   <= '0;
            inst_q     <= 16'h0000;
            valid_q    <= 1'b0;
            bubble_q   <= 1'b0;
            bcnt_q     <= 16'd0;
            hist_vld_q <= '0;
            hist_dst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            shadow_q   <= shadow_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            bubble_q   <= bubble_d;
            bcnt_q     <= bcnt_d;
            hist_vld_q <= hist_vld_d;
            hist_dst_q <= hist_dst_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign issue_inst   = inst_q;
    assign issue_valid  = valid_q;
    assign issue_bubble = bubble_q;
    assign bubble_count = bcnt_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Bench for fetch_issue_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs change only at those same points.
module tb_fetch_issue_ctrl;

    localparam int HAZ_DEPTH = 3;
    localparam int BR_SHADOW = 2;

    logic        clk = 1'b0;
    logic        rst_n, run, redirect_valid;
    logic [7:0]  redirect_addr, imem_addr, pc;
    logic [15:0] imem_data, issue_inst, bubble_count;
    logic        issue_valid, issue_bubble;
    logic [15:0] mem [256];

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    fetch_issue_ctrl #(.HAZ_DEPTH(HAZ_DEPTH), .BR_SHADOW(BR_SHADOW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .issue_inst(issue_inst), .issue_valid(issue_valid), .issue_bubble(issue_bubble),
        .pc(pc), .bubble_count(bubble_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: fetching flag, remaining shadow bubbles, queue of recent writer registers (-1 = none).
    int          m_pc, m_shadow, m_bcnt;
    bit          m_fetching, m_vld, m_bub;
    logic [15:0] m_inst;
    int          hist[$];
    logic [16:0] seen[$];

    function automatic void decode(input logic [15:0] w, output int s0, output int s1, output int d);
        s0 = -1; s1 = -1; d = -1;
        if (w == 16'h0000) return;
        if (w[15:13] == 3'b000) begin
            s0 = int'(w[2:0]); s1 = int'(w[5:3]); d = int'(w[8:6]);
        end else if (w[15:13] == 3'b001 || w[15:13] == 3'b010) begin
            s0 = int'(w[5:3]); d = int'(w[2:0]);
        end
    endfunction

    task automatic model_push(input int d);
        hist.push_front(d);
        void'(hist.pop_back());
    endtask

    task automatic model_step();
        int s0, s1, d;
        bit haz;
        m_vld = 0; m_bub = 0; m_inst = 16'h0000;
        if (!rst_n) begin
            m_pc = 0; m_shadow = 0; m_bcnt = 0; m_fetching = 0;
            hist.delete();
            for (int k = 0; k < HAZ_DEPTH; k++) hist.push_back(-1);
            return;
        end
        if (m_shadow > 0) begin
            m_vld = 1; m_bub = 1;
            if (redirect_valid) m_pc = int'(redirect_addr);
            m_shadow--;
            model_push(-1);
        end else if (!m_fetching || !run) begin
            m_fetching = run;
            model_push(-1);
        end else begin
            decode(mem[m_pc], s0, s1, d);
            haz = 0;
            foreach (hist[k]) if (hist[k] >= 0 && (hist[k] == s0 || hist[k] == s1)) haz = 1;
            m_vld = 1;
            if (haz) begin
                m_bub = 1;
                model_push(-1);
            end else begin
                m_inst = mem[m_pc];
                model_push(d);
                if (m_inst[15:13] == 3'b100) m_shadow = BR_SHADOW;
                m_pc = (m_pc + 1) % 256;
            end
        end
        if (m_bub && m_bcnt < 65535) m_bcnt++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("pc@%0d", cyc), pc, m_pc);
        check($sformatf("imem_addr@%0d", cyc), imem_addr, m_pc);
        check($sformatf("issue_valid@%0d", cyc), issue_valid, m_vld);
        check($sformatf("issue_bubble@%0d", cyc), issue_bubble, m_bub);
        check($sformatf("issue_inst@%0d", cyc), issue_inst, m_inst);
        check($sformatf("bubble_count@%0d", cyc), bubble_count, m_bcnt);
        if (issue_valid) seen.push_back({issue_bubble, issue_inst});
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b1; redirect_valid = 1'b0; redirect_addr = 8'h00;
        repeat (3) tick();
        check("rst_pc", pc, 8'h00);
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_bubble_count", bubble_count, 16'h0000);
        rst_n = 1'b1;
        seen.delete();
    endtask

    function automatic logic [15:0] rand_inst();
        logic [15:0] v;
        int k;
        v = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k == 0) return 16'h0000;
        if (k <= 3) v[15:13] = 3'b000;
        else if (k <= 6) v[15:13] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b010;
        else if (k == 7) v[15:13] = 3'b100;
        return v;
    endfunction

    // Writer r1 at mem[0], filler independents, then a reader of r1 at distance d.
    task automatic run_dist(input int d, input int exp_b);
        logic [15:0] fill [3];
        fill[0] = 16'h2033; fill[1] = 16'h202A; fill[2] = 16'h203C;
        clear_mem();
        mem[0] = 16'h2021;
        for (int k = 1; k < d; k++) mem[k] = fill[k-1];
        mem[d] = 16'h2008;
        do_reset();
        repeat (2 + d + exp_b) tick();
        check($sformatf("dist%0d_bubbles", d), bubble_count, exp_b);
        check($sformatf("dist%0d_inst", d), {issue_bubble, issue_inst}, {1'b0, 16'h2008});
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
        clear_mem();

        // RAW at distance 1 with the canonical writer/reader pair.
        mem[0] = 16'h00C0; mem[1] = 16'h0003;
        do_reset();
        tick();
        check("first_edge_idle", issue_valid, 1'b0);
        tick();
        check("first_issue", {issue_valid, issue_inst}, {1'b1, 16'h00C0});
        repeat (4) tick();
        check("raw_len", seen.size(), 5);
        check("raw_s0", seen[0], {1'b0, 16'h00C0});
        check("raw_s1", seen[1], {1'b1, 16'h0000});
        check("raw_s2", seen[2], {1'b1, 16'h0000});
        check("raw_s3", seen[3], {1'b1, 16'h0000});
        check("raw_s4", seen[4], {1'b0, 16'h0003});
        check("raw_bcnt", bubble_count, 16'd3);

        for (int d = 1; d <= 4; d++) run_dist(d, (d < 4) ? 4 - d : 0);

        // Fully independent stream: read r4..r7, write r1..r4.
        clear_mem();
        mem[0] = 16'h2021; mem[1] = 16'h202A; mem[2] = 16'h2033; mem[3] = 16'h203C;
        do_reset();
        repeat (5) tick();
        check("indep_len", seen.size(), 4);
        check("indep_last", seen[3], {1'b0, 16'h203C});
        check("indep_bcnt", bubble_count, 16'd0);
        check("indep_pc", pc, 8'h04);

        // Branch, run dropped during shadow, redirect in second shadow cycle.
        clear_mem();
        mem[0] = 16'h8000; mem[1] = 16'h2033; mem[8'h20] = 16'h2021;
        do_reset();
        tick(); tick();
        run = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_addr = 8'h20;
        tick();
        redirect_valid = 1'b0; run = 1'b1;
        tick();
        check("br_len", seen.size(), 4);
        check("br_s0", seen[0], {1'b0, 16'h8000});
        check("br_s1", seen[1], {1'b1, 16'h0000});
        check("br_s2", seen[2], {1'b1, 16'h0000});
        check("br_target", seen[3], {1'b0, 16'h2021});
        check("br_pc", pc, 8'h21);

        // Wrap through FF and pause.
        clear_mem();
        mem[0] = 16'h8000; mem[8'hFE] = 16'h2021; mem[8'hFF] = 16'h2008;
        do_reset();
        tick(); tick();
        redirect_valid = 1'b1; redirect_addr = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_pc_fe", pc, 8'hFE);
        tick();
        check("wrap_pc_ff", pc, 8'hFF);
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pause_valid", issue_valid, 1'b0);
            check("pause_pc", pc, 8'hFF);
        end
        run = 1'b1;
        tick(); tick();
        check("resume_inst", {issue_valid, issue_bubble, issue_inst}, {2'b10, 16'h2008});
        check("wrap_pc_00", pc, 8'h00);
        tick();
        check("wrap_br", issue_inst, 16'h8000);

        // Reset in the first shadow cycle.
        clear_mem();
        mem[0] = 16'h8000;
        do_reset();
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", issue_valid, 1'b0);
        check("mid_rst_pc", pc, 8'h00);
        check("mid_rst_bubble", issue_bubble, 1'b0);
        rst_n = 1'b1;
        tick();
        check("mid_rst_idle", issue_valid, 1'b0);
        tick();
        check("mid_rst_reissue", {issue_valid, issue_inst}, {1'b1, 16'h8000});

        // Randomized traffic with occasional resets.
        for (int a = 0; a < 256; a++) mem[a] = rand_inst();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n          = ($urandom_range(0, 299) != 0);
            run            = ($urandom_range(0, 9) != 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            redirect_addr  = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
